// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline registers and pipe_hazard_ctrl.
// master drives the ID/EX hazard information; slave (the controller) drives enables/flushes.
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rt;
   logic                  id_is_mul;
   logic                  id_ex_memread;
   logic [REG_ADDR_W-1:0] id_ex_rt;
   logic                  ex_branch_taken;
   logic                  mem_busy;
   logic                  pc_en;
   logic                  if_id_en;
   logic                  if_id_flush;
   logic                  id_ex_en;
   logic                  id_ex_bubble;
   logic                  ex_mem_en;
   logic                  ex_mem_bubble;
   logic                  mul_busy;
   logic [CNT_W-1:0]      stall_cycles;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_is_mul, id_ex_memread, id_ex_rt,
             ex_branch_taken, mem_busy,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
             ex_mem_bubble, mul_busy, stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_is_mul, id_ex_memread, id_ex_rt,
             ex_branch_taken, mem_busy,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
             ex_mem_bubble, mul_busy, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, MUL occupancy, mem wait.
// Optional stall-cycle counter is built only when STALL_PERF_CNT_EN is defined.
//
// state      | meaning
// S_RST      | in reset, pipe held with all stages cleared
// S_RUN      | normal issue, hazards resolved by priority
// S_MUL_WAIT | multiply occupying EX, front end frozen
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 16
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int MC_W = $clog2(MUL_CYCLES) + 1;
   localparam logic [MC_W-1:0] MUL_LOAD = MC_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);

   typedef enum logic [1:0] {S_RST, S_RUN, S_MUL_WAIT} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [MC_W-1:0] r_mul_cnt;
   logic            w_load_use;
   logic            w_mul_start;
   logic            w_pc_en;
   logic            w_if_id_en;
   logic            w_if_id_flush;
   logic            w_id_ex_en;
   logic            w_id_ex_bubble;
   logic            w_ex_mem_en;
   logic            w_ex_mem_bubble;
   logic            w_mul_busy;

   assign w_load_use = bus.id_ex_memread && (bus.id_ex_rt != '0) &&
                       ((bus.id_ex_rt == bus.id_rs) ||
                        (bus.id_uses_rt && (bus.id_ex_rt == bus.id_rt)));

   // A MUL only starts once nothing of higher priority claims the cycle.
   assign w_mul_start = (MUL_CYCLES > 1) && bus.id_is_mul && !bus.mem_busy &&
                        !bus.ex_branch_taken && !w_load_use;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_RST;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mul_cnt <= '0;
      end else if (r_state == S_RUN && w_mul_start) begin
         r_mul_cnt <= MUL_LOAD;
      end else if (r_state == S_MUL_WAIT && !bus.mem_busy && r_mul_cnt != '0) begin
         r_mul_cnt <= r_mul_cnt - MC_W'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:      w_next = S_RUN;
         S_RUN:      if (w_mul_start) w_next = S_MUL_WAIT;
         S_MUL_WAIT: if (!bus.mem_busy && r_mul_cnt == '0) w_next = S_RUN;
         default:    w_next = S_RST;
      endcase
   end

   always_comb begin
      w_pc_en         = 1'b1;
      w_if_id_en      = 1'b1;
      w_if_id_flush   = 1'b0;
      w_id_ex_en      = 1'b1;
      w_id_ex_bubble  = 1'b0;
      w_ex_mem_en     = 1'b1;
      w_ex_mem_bubble = 1'b0;
      w_mul_busy      = 1'b0;
      case (r_state)
         S_RUN: begin
            if (bus.mem_busy) begin
               w_pc_en     = 1'b0;
               w_if_id_en  = 1'b0;
               w_id_ex_en  = 1'b0;
               w_ex_mem_en = 1'b0;
            end else if (bus.ex_branch_taken) begin
               w_if_id_flush  = 1'b1;
               w_id_ex_bubble = 1'b1;
            end else if (w_load_use) begin
               w_pc_en        = 1'b0;
               w_if_id_en     = 1'b0;
               w_id_ex_bubble = 1'b1;
            end
         end
         S_MUL_WAIT: begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_ex_mem_en     = !bus.mem_busy;
            w_ex_mem_bubble = !bus.mem_busy;
            w_mul_busy      = 1'b1;
         end
         default: begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_ex_mem_en     = 1'b0;
            w_if_id_flush   = 1'b1;
            w_id_ex_bubble  = 1'b1;
            w_ex_mem_bubble = 1'b1;
         end
      endcase
   end

   assign bus.pc_en         = w_pc_en;
   assign bus.if_id_en      = w_if_id_en;
   assign bus.if_id_flush   = w_if_id_flush;
   assign bus.id_ex_en      = w_id_ex_en;
   assign bus.id_ex_bubble  = w_id_ex_bubble;
   assign bus.ex_mem_en     = w_ex_mem_en;
   assign bus.ex_mem_bubble = w_ex_mem_bubble;
   assign bus.mul_busy      = w_mul_busy;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   // Saturating: a long stall must not wrap back to a small count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (r_state != S_RST && !w_pc_en && r_stall_cnt != {CNT_W{1'b1}}) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign bus.stall_cycles = r_stall_cnt;
`else
   assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan sequences plus random traffic on two
// configurations (MUL_CYCLES=4/CNT_W=16 and MUL_CYCLES=1/CNT_W=4), checked against a cycle model.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [4:0] t_rs, t_rt, t_ex_rt;
   logic       t_uses_rt, t_mul, t_memread, t_br, t_mb;

   pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) if0();
   pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  if1();

   assign if0.id_rs = t_rs;            assign if1.id_rs = t_rs;
   assign if0.id_rt = t_rt;            assign if1.id_rt = t_rt;
   assign if0.id_uses_rt = t_uses_rt;  assign if1.id_uses_rt = t_uses_rt;
   assign if0.id_is_mul = t_mul;       assign if1.id_is_mul = t_mul;
   assign if0.id_ex_memread = t_memread; assign if1.id_ex_memread = t_memread;
   assign if0.id_ex_rt = t_ex_rt;      assign if1.id_ex_rt = t_ex_rt;
   assign if0.ex_branch_taken = t_br;  assign if1.ex_branch_taken = t_br;
   assign if0.mem_busy = t_mb;         assign if1.mem_busy = t_mb;

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .MUL_CYCLES(4), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .bus(if0));
   pipe_hazard_ctrl #(.REG_ADDR_W(5), .MUL_CYCLES(1), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .bus(if1));

   logic [7:0] got0, got1;
   assign got0 = {if0.pc_en, if0.if_id_en, if0.if_id_flush, if0.id_ex_en,
                  if0.id_ex_bubble, if0.ex_mem_en, if0.ex_mem_bubble, if0.mul_busy};
   assign got1 = {if1.pc_en, if1.if_id_en, if1.if_id_flush, if1.id_ex_en,
                  if1.id_ex_bubble, if1.ex_mem_en, if1.ex_mem_bubble, if1.mul_busy};

`ifdef STALL_PERF_CNT_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   // model: per configuration, "in reset", remaining multiply-wait cycles, stall count
   bit m_rst[2];
   int m_busy[2];
   int m_stall[2];
   int mc[2];
   int smax[2];

   int n_total = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit lu();
      return t_memread && (t_ex_rt != 0) &&
             ((t_ex_rt == t_rs) || (t_uses_rt && (t_ex_rt == t_rt)));
   endfunction

   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, ex_mem_bubble, mul_busy}
   function automatic logic [7:0] exp_out(input int i);
      if (m_rst[i])         return 8'b0010_1010;
      if (m_busy[i] > 0)    return t_mb ? 8'b0000_0001 : 8'b0000_0111;
      if (t_mb)             return 8'b0000_0000;
      if (t_br)             return 8'b1111_1100;
      if (lu())             return 8'b0001_1100;
      return 8'b1101_0100;
   endfunction

   task automatic model_clock(input int i);
      logic [7:0] e;
      e = exp_out(i);
      if (m_rst[i]) begin
         m_rst[i] = 1'b0;
      end else begin
         if (FEAT && !e[7]) m_stall[i] = (m_stall[i] < smax[i]) ? m_stall[i] + 1 : smax[i];
         if (m_busy[i] > 0) begin
            if (!t_mb) m_busy[i]--;
         end else if (!t_mb && !t_br && t_mul && !lu() && mc[i] > 1) begin
            m_busy[i] = mc[i] - 1;
         end
      end
   endtask

   task automatic apply();
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_rst[i] = 1'b1; m_busy[i] = 0; m_stall[i] = 0;
         end
      end
      @(negedge clk);
      chk("outs_cfg0", {24'b0, got0}, {24'b0, exp_out(0)});
      chk("stall_cfg0", {16'b0, if0.stall_cycles}, m_stall[0]);
      chk("outs_cfg1", {24'b0, got1}, {24'b0, exp_out(1)});
      chk("stall_cfg1", {28'b0, if1.stall_cycles}, m_stall[1]);
      @(posedge clk);
      if (!reset) for (int i = 0; i < 2; i++) model_clock(i);
      #1;
   endtask

   task automatic idle_inputs();
      t_rs = 0; t_rt = 0; t_ex_rt = 0; t_uses_rt = 0; t_mul = 0;
      t_memread = 0; t_br = 0; t_mb = 0;
   endtask

   initial begin
      mc[0] = 4;  smax[0] = 65535;
      mc[1] = 1;  smax[1] = 15;
      idle_inputs();
      reset = 1'b1;
      repeat (3) apply();
      reset = 1'b0;
      repeat (2) apply();

      // load-use on rs, then $0 destination, then rt match with rt unused
      t_memread = 1; t_ex_rt = 8; t_rs = 8; apply();
      apply();
      t_ex_rt = 0; t_rs = 0; apply();
      t_ex_rt = 8; t_rs = 1; t_rt = 8; t_uses_rt = 0; apply();
      t_uses_rt = 1; apply();
      // taken branch beats load-use
      t_rs = 8; t_br = 1; apply();
      idle_inputs(); apply();

      // MUL pulse
      t_mul = 1; apply();
      t_mul = 0; repeat (5) apply();

      // MUL with two cycles of memory wait in the middle
      t_mul = 1; apply();
      t_mul = 0; apply();
      t_mb = 1; repeat (2) apply();
      t_mb = 0; repeat (4) apply();

      // MUL together with load-use: bubble first, MUL issues after
      t_mul = 1; t_memread = 1; t_ex_rt = 3; t_rs = 3; apply();
      t_memread = 0; apply();
      t_mul = 0; repeat (4) apply();

      // reset in the middle of a multiply
      t_mul = 1; apply();
      t_mul = 0; apply();
      reset = 1'b1; apply();
      reset = 1'b0; repeat (2) apply();

      // long memory stall to saturate the small counter
      t_mb = 1; repeat (20) apply();
      t_mb = 0; apply();

      for (int n = 0; n < 2000; n++) begin
         t_rs      = 5'($urandom_range(0, 3));
         t_rt      = 5'($urandom_range(0, 3));
         t_ex_rt   = 5'($urandom_range(0, 3));
         t_uses_rt = 1'($urandom_range(0, 1));
         t_memread = 1'($urandom_range(0, 1));
         t_mul     = ($urandom_range(0, 4) == 0);
         t_br      = ($urandom_range(0, 7) == 0);
         t_mb      = ($urandom_range(0, 7) == 0);
         reset     = ($urandom_range(0, 59) == 0);
         apply();
      end
      reset = 1'b0;
      idle_inputs();
      apply();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
